// File: rtl/pid_wall_follower_pkg.sv
// Shared types and helpers for the wall-follower sensor and control path.
package pid_wall_follower_pkg;

   localparam int unsigned US_PER_CM = 58;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } ranger_state_t;

   // Bits needed for a counter that runs 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input, with rise/fall pulses
// derived from the synchronised level and its registered previous value.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q;
   assign rise_c   = sync_q & ~prev_q;
   assign fall_c   = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo pulse timing, and conversion
// of the echo width into whole centimetres with timeout reporting.
module ultrasonic_ranger
   import pid_wall_follower_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned PV_WIDTH    = 9,
   parameter int unsigned TRIG_US     = 10,
   parameter int unsigned TIMEOUT_US  = 38000,
   parameter int unsigned PERIOD_US   = 60000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                echo,
   output logic                trig,
   output logic [PV_WIDTH-1:0] distance,
   output logic                distance_valid,
   output logic                timeout,
   output logic                busy
);

   localparam int unsigned CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned CLKS_PER_CM = US_PER_CM * CLKS_PER_US;
   localparam int unsigned TRIG_CYC    = TRIG_US * CLKS_PER_US;
   localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CLKS_PER_US;
   localparam int unsigned PERIOD_CYC  = PERIOD_US * CLKS_PER_US;

   // One counter times both the trigger pulse and the echo timeouts.
   localparam int unsigned CNT_W = cnt_width((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC);
   localparam int unsigned PER_W = cnt_width(PERIOD_CYC);
   localparam int unsigned SUB_W = cnt_width(CLKS_PER_CM);

   localparam logic [CNT_W-1:0]    TRIG_LAST = CNT_W'(TRIG_CYC - 1);
   localparam logic [CNT_W-1:0]    TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(PERIOD_CYC - 1);
   localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(CLKS_PER_CM - 1);
   localparam logic [PV_WIDTH-1:0] CM_MAX    = '1;

   logic echo_sync, echo_rise_c, echo_fall_c;

   sync_edge_detect u_echo_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (echo),
      .sync_out (echo_sync),
      .rise_c   (echo_rise_c),
      .fall_c   (echo_fall_c)
   );

   ranger_state_t       state_q, state_d;
   logic                trig_q, trig_d;
   logic [PV_WIDTH-1:0] distance_q, distance_d;
   logic                valid_q, valid_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PER_W-1:0]    per_q, per_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [PV_WIDTH-1:0] cm_q, cm_d;

   logic                sub_wrap;
   logic [PV_WIDTH-1:0] cm_inc;

   // Next-state and output logic; the fall cycle itself is counted, so a
   // wrap on that cycle is folded into the published distance.
   always_comb begin
      sub_wrap   = (sub_q == SUB_LAST);
      cm_inc     = (cm_q == CM_MAX) ? cm_q : cm_q + PV_WIDTH'(1);

      state_d    = state_q;
      trig_d     = trig_q;
      distance_d = distance_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;
      cnt_d      = cnt_q;
      per_d      = (per_q == PER_LAST) ? per_q : per_q + PER_W'(1);
      sub_d      = sub_q;
      cm_d       = cm_q;

      case (state_q)
         IDLE: begin
            per_d = '0;
            cnt_d = '0;
            if (en) begin
               state_d = TRIG;
               trig_d  = 1'b1;
            end
         end
         TRIG: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TRIG_LAST) begin
               trig_d  = 1'b0;
               cnt_d   = '0;
               state_d = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (echo_rise_c) begin
               cnt_d   = '0;
               sub_d   = '0;
               cm_d    = '0;
               state_d = MEASURE;
            end else if (cnt_q == TMO_LAST) begin
               distance_d = CM_MAX;
               timeout_d  = 1'b1;
               valid_d    = 1'b1;
               state_d    = HOLDOFF;
            end
         end
         MEASURE: begin
            cnt_d = cnt_q + CNT_W'(1);
            sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
            if (sub_wrap) cm_d = cm_inc;
            if (echo_fall_c) begin
               distance_d = sub_wrap ? cm_inc : cm_q;
               timeout_d  = 1'b0;
               valid_d    = 1'b1;
               state_d    = HOLDOFF;
            end else if (cnt_q == TMO_LAST) begin
               distance_d = CM_MAX;
               timeout_d  = 1'b1;
               valid_d    = 1'b1;
               state_d    = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if ((per_q == PER_LAST) && !echo_sync) begin
               if (en) begin
                  state_d = TRIG;
                  trig_d  = 1'b1;
                  per_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Dropping en abandons whatever is in flight without publishing.
      if (!en) begin
         state_d    = IDLE;
         trig_d     = 1'b0;
         valid_d    = 1'b0;
         distance_d = distance_q;
         timeout_d  = timeout_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         trig_q     <= 1'b0;
         distance_q <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         per_q      <= '0;
         sub_q      <= '0;
         cm_q       <= '0;
      end else begin
         state_q    <= state_d;
         trig_q     <= trig_d;
         distance_q <= distance_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         per_q      <= per_d;
         sub_q      <= sub_d;
         cm_q       <= cm_d;
      end
   end

   assign trig           = trig_q;
   assign distance       = distance_q;
   assign distance_valid = valid_q;
   assign timeout        = timeout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomised bench for ultrasonic_ranger: two instances run the long
// timeout/period scenarios side by side against a pulse-width reference model.
module tb_ultrasonic_ranger;

   localparam int unsigned CLK_FREQ_HZ = 1_000_000;
   localparam int unsigned PV_WIDTH    = 9;
   localparam int unsigned TRIG_US     = 10;
   localparam int unsigned TIMEOUT_US  = 38000;
   localparam int unsigned PERIOD_US   = 60000;

   // One clock per microsecond, so cycle counts equal microsecond counts.
   localparam int CYC_PER_CM  = 58;
   localparam int TRIG_CYC    = 10;
   localparam int TIMEOUT_CYC = 38000;
   localparam int PERIOD_CYC  = 60000;
   localparam int DIST_MAX    = (1 << PV_WIDTH) - 1;

   logic clk = 1'b0;
   logic [1:0] reset_v;
   logic [1:0] en_v;
   logic [1:0] echo_v;
   logic [1:0] trig_v;
   logic [1:0] valid_v;
   logic [1:0] tmo_v;
   logic [1:0] busy_v;
   logic [PV_WIDTH-1:0] dist_v [2];

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   int vcount [2];

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++)
         if (valid_v[k]) vcount[k] <= vcount[k] + 1;
   end

   ultrasonic_ranger #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ), .PV_WIDTH(PV_WIDTH), .TRIG_US(TRIG_US),
      .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US)
   ) u_dut_a (
      .clk(clk), .reset(reset_v[0]), .en(en_v[0]), .echo(echo_v[0]),
      .trig(trig_v[0]), .distance(dist_v[0]), .distance_valid(valid_v[0]),
      .timeout(tmo_v[0]), .busy(busy_v[0])
   );

   ultrasonic_ranger #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ), .PV_WIDTH(PV_WIDTH), .TRIG_US(TRIG_US),
      .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US)
   ) u_dut_b (
      .clk(clk), .reset(reset_v[1]), .en(en_v[1]), .echo(echo_v[1]),
      .trig(trig_v[1]), .distance(dist_v[1]), .distance_valid(valid_v[1]),
      .timeout(tmo_v[1]), .busy(busy_v[1])
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: whole centimetres in an echo of the given width, saturated.
   function automatic int ref_cm(input int high_cyc);
      int cm;
      cm = high_cyc / CYC_PER_CM;
      return (cm > DIST_MAX) ? DIST_MAX : cm;
   endfunction

   task automatic wait_trig(input int k, input int budget, output int waited);
      waited = 0;
      while (trig_v[k] !== 1'b1 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (trig_v[k] !== 1'b1) check("trig_wait_expired", 0, 1);
   endtask

   // Entered at the negedge where trig is first seen high.
   task automatic trig_width(input int k, output int width);
      width = 0;
      while (trig_v[k] === 1'b1 && width < 100) begin
         width++;
         @(negedge clk);
      end
   endtask

   task automatic drive_echo(input int k, input logic v);
      @(posedge clk);
      #1 echo_v[k] = v;
   endtask

   task automatic restart(input int k, input string tag);
      @(posedge clk);
      #1 en_v[k] = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_off_trig"}, int'(trig_v[k]), 0);
      check({tag, "_off_busy"}, int'(busy_v[k]), 0);
      en_v[k] = 1'b1;
   endtask

   // One echo pulse of `high` cycles, `delay` cycles after trig falls.
   task automatic measure(input int k, input int delay, input int high,
                          input string tag, output int t_rise);
      int w, width, seen_at, pulses, got_d, got_t, exp_d;
      wait_trig(k, 5, w);
      t_rise = cyc_n;
      trig_width(k, width);
      check({tag, "_trig_width"}, width, TRIG_CYC);
      repeat (delay - 1) @(posedge clk);
      drive_echo(k, 1'b1);
      repeat (high - 1) @(posedge clk);
      drive_echo(k, 1'b0);
      exp_d = ref_cm(high);
      seen_at = 0; pulses = 0; got_d = -1; got_t = -1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         if (valid_v[k]) begin
            pulses++;
            if (seen_at == 0) seen_at = i;
            got_d = int'(dist_v[k]);
            got_t = int'(tmo_v[k]);
         end
      end
      check({tag, "_valid_edge"}, seen_at, 3);
      check({tag, "_valid_pulses"}, pulses, 1);
      check({tag, "_distance"}, got_d, exp_d);
      check({tag, "_timeout"}, got_t, 0);
      check({tag, "_hold"}, int'(dist_v[k]), exp_d);
   endtask

   task automatic run_a();
      int w, width, t1, t2, hi, dly, d_prev, t_prev, vc0;
      en_v[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         case (i)
            0: hi = 5800;
            1: hi = 57;
            2: hi = 115;
            3: hi = 58;
            4: hi = 1;
            5: hi = 116;
            default: hi = int'($urandom_range(1800, 1));
         endcase
         dly = (i == 0) ? 100 : int'($urandom_range(200, 1));
         measure(0, dly, hi, $sformatf("m%0d_w%0d", i, hi), t1);
         restart(0, $sformatf("m%0d", i));
      end

      // Abort in the middle of an echo pulse.
      wait_trig(0, 5, w);
      trig_width(0, width);
      d_prev = int'(dist_v[0]);
      t_prev = int'(tmo_v[0]);
      drive_echo(0, 1'b1);
      repeat (500) @(posedge clk);
      #1;
      check("abort_busy_before", int'(busy_v[0]), 1);
      vc0 = vcount[0];
      en_v[0] = 1'b0;
      @(posedge clk);
      #1;
      check("abort_trig", int'(trig_v[0]), 0);
      check("abort_busy", int'(busy_v[0]), 0);
      drive_echo(0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_valid", vcount[0] - vc0, 0);
      check("abort_dist_kept", int'(dist_v[0]), d_prev);
      check("abort_tmo_kept", int'(tmo_v[0]), t_prev);
      en_v[0] = 1'b1;
      wait_trig(0, 2, w);
      check("reassert_trig_fast", int'(w <= 2), 1);

      // Saturation on a long echo, then the next trigger exactly one period on.
      restart(0, "pre_sat");
      measure(0, 100, 34800, "sat", t1);
      wait_trig(0, PERIOD_CYC + 100, w);
      t2 = cyc_n;
      check("period", t2 - t1, PERIOD_CYC);

      // Asynchronous reset while trig is high.
      #1 reset_v[0] = 1'b1;
      #1;
      check("areset_trig", int'(trig_v[0]), 0);
      check("areset_dist", int'(dist_v[0]), 0);
      check("areset_valid", int'(valid_v[0]), 0);
      check("areset_tmo", int'(tmo_v[0]), 0);
      check("areset_busy", int'(busy_v[0]), 0);
      #3 reset_v[0] = 1'b0;
   endtask

   task automatic run_b();
      int w, width, n;
      en_v[1] = 1'b1;

      // No echo at all: the wait for a rising edge expires.
      wait_trig(1, 5, w);
      trig_width(1, width);
      check("norise_trig_width", width, TRIG_CYC);
      check("norise_busy", int'(busy_v[1]), 1);
      n = 0;
      while (!valid_v[1] && n < TIMEOUT_CYC + 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("norise_latency", n, TIMEOUT_CYC);
      check("norise_dist", int'(dist_v[1]), DIST_MAX);
      check("norise_tmo", int'(tmo_v[1]), 1);
      @(posedge clk);
      #1;
      check("norise_one_cycle", int'(valid_v[1]), 0);
      check("norise_tmo_held", int'(tmo_v[1]), 1);
      restart(1, "b");

      // Echo stuck high: abandoned once it has been high for the timeout.
      wait_trig(1, 5, w);
      trig_width(1, width);
      repeat (49) @(posedge clk);
      drive_echo(1, 1'b1);
      n = 0;
      while (!valid_v[1] && n < TIMEOUT_CYC + 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("stuck_latency", n, TIMEOUT_CYC + 3);
      check("stuck_dist", int'(dist_v[1]), DIST_MAX);
      check("stuck_tmo", int'(tmo_v[1]), 1);
      drive_echo(1, 1'b0);
      en_v[1] = 1'b0;
   endtask

   initial begin
      reset_v = 2'b11;
      en_v    = 2'b00;
      echo_v  = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst%0d_trig", k), int'(trig_v[k]), 0);
         check($sformatf("rst%0d_dist", k), int'(dist_v[k]), 0);
         check($sformatf("rst%0d_valid", k), int'(valid_v[k]), 0);
         check($sformatf("rst%0d_tmo", k), int'(tmo_v[k]), 0);
         check($sformatf("rst%0d_busy", k), int'(busy_v[k]), 0);
      end
      reset_v = 2'b00;
      fork
         run_a();
         run_b();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc_n);
      $fatal(1);
   end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Drives an HC-SR04-style ultrasonic sensor and converts its echo pulse width into an unsigned distance in whole centimetres.
- Sits upstream of the PID controller and produces the process value that feeds the controller's feedback input.
- Its one-cycle distance_valid strobe is the controller's clk_en, so the controller updates once per new measurement.
- Runs measurements back-to-back at a fixed period while enabled.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- PV_WIDTH, 9, distance output width; must match the PID controller's PV_WIDTH.
- TRIG_US, 10, trigger pulse width in microseconds.
- TIMEOUT_US, 38000, maximum wait for echo rise, and maximum echo high time, in microseconds.
- PERIOD_US, 60000, minimum time between successive trigger rising edges, in microseconds.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  measurement enable, synchronous.
- echo  in  1  raw echo pin; asynchronous to clk.
- trig  out  1  trigger pulse to the sensor.
- distance  out  PV_WIDTH  last measured distance in cm, unsigned.
- distance_valid  out  1  one-cycle strobe when distance and timeout update.
- timeout  out  1  the last measurement timed out; valid alongside distance.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values: trig=0, distance=0, distance_valid=0, timeout=0, busy=0, state=IDLE, all counters=0, synchroniser flops=0.
- Derived constants:
  - CLKS_PER_US = CLK_FREQ_HZ/1_000_000.
  - CLKS_PER_CM = 58*CLKS_PER_US.
  - TRIG_CYC, TIMEOUT_CYC and PERIOD_CYC are the corresponding _US parameter times CLKS_PER_US.
- Echo input path:
  - echo passes through a 2-flop synchroniser, then a registered-previous edge detector.
  - rise = s & ~p; fall = ~s & p.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE:
  - If en=1, go to TRIG next cycle, clear the period counter and set trig=1.
- TRIG:
  - trig held high for exactly TRIG_CYC cycles, then trig=0 and go to WAIT_RISE with the timeout counter cleared.
  - The period counter runs from the first TRIG cycle.
- WAIT_RISE:
  - On rise: go to MEASURE, clear the cm counter and sub-counter.
  - If the timeout counter reaches TIMEOUT_CYC-1 first, publish distance = 2^PV_WIDTH-1, timeout=1, pulse distance_valid, and go to HOLDOFF.
  - An echo already high on entry is ignored; only a rising edge starts a measurement.
- MEASURE:
  - The sub-counter counts 0..CLKS_PER_CM-1; on wrap, the cm counter increments, saturating at 2^PV_WIDTH-1.
  - The result is floored: partial centimetres are discarded.
  - On fall: publish distance = cm counter, timeout=0, pulse distance_valid, and go to HOLDOFF.
  - If echo stays high for TIMEOUT_CYC cycles: publish saturated max, timeout=1, pulse distance_valid, and go to HOLDOFF.
- HOLDOFF:
  - Wait until the period counter reaches PERIOD_CYC-1 AND the synchronised echo is 0.
  - Then go to TRIG if en=1, else IDLE.
- Latency: distance_valid is high for exactly one cycle, on the 3rd rising clk edge after the echo pin falls (2 sync stages plus registered output).
- distance and timeout hold their values between strobes and are never modified except together with distance_valid.
- en deasserted in any state:
  - Next cycle: state=IDLE, trig=0.
  - An in-flight measurement is discarded with no distance_valid; distance and timeout keep their prior values.
- en reasserted: a fresh measurement starts from IDLE; there is no holdoff carry-over.
- Reset mid-measurement: trig drops immediately (asynchronously) and all outputs return to their reset values.
- Simultaneous events: fall and timeout terminal count in the same cycle counts as a normal fall (timeout=0). Saturation is not a timeout.

Decomposition:
- Shared package pid_wall_follower_pkg holds:
  - the US_PER_CM=58 constant;
  - the ranger_state_t enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF);
  - a clog2-based counter-width helper.
- One sub-module, sync_edge_detect: a 2-flop synchroniser plus rise/fall pulses, async reset to 0. It is reusable for other sensor inputs.
- Counters and the FSM live in ultrasonic_ranger.

Test Plan:
- Bench parameters for all tests: CLK_FREQ_HZ=1_000_000, TIMEOUT_US=38000, PERIOD_US=60000.
- Basic: en=1 after reset -> trig high exactly 10 cycles. Echo rises 100 cycles later and stays high 5800 cycles -> distance=100, timeout=0, distance_valid one cycle, 3 edges after echo falls.
- Floor and zero: echo high 57 cycles -> distance=0. Echo high 115 cycles -> distance=1.
- Saturation: PV_WIDTH=9, echo high 34800 cycles (600 cm) -> distance=511, timeout=0.
- Timeouts:
  - No echo after trig -> after 38000 cycles in WAIT_RISE, distance=511, timeout=1, one distance_valid.
  - Echo stuck high -> same result from MEASURE.
- Periodicity and en abort:
  - Second trig rising edge exactly 60000 cycles after the first.
  - Drop en mid-MEASURE -> trig=0, busy=0 next cycle, no distance_valid, distance keeps its prior value.
  - Reassert en -> a new trig pulse starts within 2 cycles.
- Async reset asserted during TRIG -> trig=0 immediately without a clock edge; all outputs return to their reset values.
